// File: rtl/intt_burst_scheduler.sv
// rtl/intt_burst_scheduler.sv - round-robin burst scheduler sharing one pipelined iNTT between two sources
module intt_burst_scheduler #(
    parameter int BURST = 32,
    parameter int LAT   = 12,
    parameter int W     = 12
) (
    input  logic           clk,
    input  logic           r,
    input  logic           s0_valid,
    output logic           s0_ready,
    input  logic [8*W-1:0] s0_coeffs,
    input  logic           s1_valid,
    output logic           s1_ready,
    input  logic [8*W-1:0] s1_coeffs,
    output logic           nt_valid_in,
    output logic [8*W-1:0] nt_coeffs,
    input  logic           nt_valid_out,
    input  logic [8*W-1:0] nt_coeffs_out,
    output logic [8*W-1:0] d_coeffs,
    output logic           d0_valid,
    output logic           d1_valid,
    output logic           d0_last,
    output logic           d1_last,
    output logic           busy,
    output logic           sync_err
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            ptr;
    logic            issue_id;
    logic            issue_last;
    logic [LAT-1:0]  tag_v;
    logic [LAT-1:0]  tag_id;
    logic [LAT-1:0]  tag_last;

    logic accept;
    logic gid;
    logic burst_end;
    logic hit_v;
    logic hit_id;
    logic hit_last;
    logic match;

    assign s0_ready  = (state == GNT0);
    assign s1_ready  = (state == GNT1);
    assign gid       = (state == GNT1);
    assign accept    = (s0_ready & s0_valid) | (s1_ready & s1_valid);
    assign burst_end = accept && (count == CW'(BURST - 1));

    // The oldest tag entry lines up with the iNTT result appearing this cycle.
    assign hit_v    = tag_v[LAT-1];
    assign hit_id   = tag_id[LAT-1];
    assign hit_last = tag_last[LAT-1];
    assign match    = hit_v & nt_valid_out;

    // A beat registered into nt_valid_in is in flight even before it enters the tag line.
    assign busy = (state != IDLE) | nt_valid_in | (|tag_v);

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state <= IDLE;
            count <= '0;
            ptr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid && s1_valid)
                        state <= ptr ? GNT1 : GNT0;
                    else if (s0_valid)
                        state <= GNT0;
                    else if (s1_valid)
                        state <= GNT1;
                end
                GNT0: begin
                    if (burst_end) begin
                        count <= '0;
                        ptr   <= 1'b1;
                        state <= s1_valid ? GNT1 : (s0_valid ? GNT0 : IDLE);
                    end else if (accept) begin
                        count <= count + 1'b1;
                    end
                end
                GNT1: begin
                    if (burst_end) begin
                        count <= '0;
                        ptr   <= 1'b0;
                        state <= s0_valid ? GNT0 : (s1_valid ? GNT1 : IDLE);
                    end else if (accept) begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            nt_valid_in <= 1'b0;
            nt_coeffs   <= '0;
            issue_id    <= 1'b0;
            issue_last  <= 1'b0;
        end else begin
            nt_valid_in <= accept;
            issue_id    <= gid;
            issue_last  <= burst_end;
            if (accept)
                nt_coeffs <= gid ? s1_coeffs : s0_coeffs;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            tag_v    <= '0;
            tag_id   <= '0;
            tag_last <= '0;
        end else begin
            tag_v[0]    <= nt_valid_in;
            tag_id[0]   <= issue_id;
            tag_last[0] <= issue_last;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_id[i]   <= tag_id[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    // Results without a tag are dropped; tags without a result are discarded.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            d0_valid <= 1'b0;
            d1_valid <= 1'b0;
            d0_last  <= 1'b0;
            d1_last  <= 1'b0;
            d_coeffs <= '0;
            sync_err <= 1'b0;
        end else begin
            d0_valid <= match & ~hit_id;
            d1_valid <= match & hit_id;
            d0_last  <= match & ~hit_id & hit_last;
            d1_last  <= match & hit_id & hit_last;
            if (match)
                d_coeffs <= nt_coeffs_out;
            if (nt_valid_out != hit_v)
                sync_err <= 1'b1;
        end
    end

endmodule
